// File: rtl/nearest_hit_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : nearest_hit_scheduler
//  Purpose  : Per-pixel sphere scan. Issues one intersection test per sphere,
//             collects the in-order results and reports the nearest positive
//             hit together with the captured pixel coordinates.
//  Revision : 1.0  initial release
// ============================================================================
module nearest_hit_scheduler #(
    parameter int N_SPHERES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    output logic        sph_req,
    output logic [7:0]  sph_idx,
    input  logic        isect_valid,
    input  logic        isect_hit,
    input  logic [11:0] isect_t,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_hit,
    output logic [7:0]  out_idx,
    output logic [11:0] out_t,
    output logic [9:0]  out_x,
    output logic [9:0]  out_y,
    output logic        err
);

    // Index of the final sphere; counters are 9 bits so 255 spheres never wrap.
    localparam logic [8:0]         c_LAST_IDX = 9'(N_SPHERES - 1);
    // "No hit yet" distance; a result equal to it can never win the strict compare.
    localparam logic signed [11:0] c_T_FAR    = 12'sh7FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [8:0]         r_issue_cnt;
    logic [8:0]         r_rcv_cnt;
    logic               r_best_hit;
    logic [7:0]         r_best_idx;
    logic signed [11:0] r_best_t;
    logic [9:0]         r_x;
    logic [9:0]         r_y;
    logic               r_err;

    logic signed [11:0] w_t;
    logic               w_rcv;
    logic               w_better;

    assign w_t      = isect_t;
    // Results are only meaningful while a scan is in flight.
    assign w_rcv    = ((r_state == ISSUE) || (r_state == DRAIN)) && isect_valid;
    // Strict less-than keeps the lower index on equal distances.
    assign w_better = isect_hit && (w_t > 12'sd0) && (w_t < r_best_t);
    assign err      = r_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_state_next = r_state;
        pix_ready    = 1'b0;
        sph_req      = 1'b0;
        sph_idx      = 8'd0;
        out_valid    = 1'b0;
        out_hit      = 1'b0;
        out_idx      = 8'd0;
        out_t        = c_T_FAR;
        out_x        = 10'd0;
        out_y        = 10'd0;
        case (r_state)
            IDLE: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                sph_req = 1'b1;
                sph_idx = r_issue_cnt[7:0];
                if (r_issue_cnt == c_LAST_IDX) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (isect_valid && (r_rcv_cnt == c_LAST_IDX)) begin
                    w_state_next = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                out_hit   = r_best_hit;
                out_idx   = r_best_idx;
                out_t     = r_best_t;
                out_x     = r_x;
                out_y     = r_y;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Pixel capture, issue/receive counters, running best and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_cnt <= 9'd0;
            r_rcv_cnt   <= 9'd0;
            r_best_hit  <= 1'b0;
            r_best_idx  <= 8'd0;
            r_best_t    <= c_T_FAR;
            r_x         <= 10'd0;
            r_y         <= 10'd0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (pix_valid) begin
                        r_x         <= pix_x;
                        r_y         <= pix_y;
                        r_issue_cnt <= 9'd0;
                        r_rcv_cnt   <= 9'd0;
                        r_best_hit  <= 1'b0;
                        r_best_idx  <= 8'd0;
                        r_best_t    <= c_T_FAR;
                    end
                end
                ISSUE: begin
                    r_issue_cnt <= r_issue_cnt + 9'd1;
                end
                OUT: begin
                    // A result with no outstanding request is a protocol error.
                    if (isect_valid) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase

            // Results arrive in issue order, so the receive count names the sphere.
            if (w_rcv) begin
                r_rcv_cnt <= r_rcv_cnt + 9'd1;
                if (w_better) begin
                    r_best_hit <= 1'b1;
                    r_best_idx <= r_rcv_cnt[7:0];
                    r_best_t   <= w_t;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nearest_hit_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_nearest_hit_scheduler
//  Purpose  : Directed self-checking bench for nearest_hit_scheduler (N=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_nearest_hit_scheduler;

    // Result sets, packed with sphere 0 in the low slice.
    localparam logic [3:0]  c_BASIC_H = 4'b1011;
    localparam logic [47:0] c_BASIC_T = {12'd30, 12'd10, 12'd24, 12'd40};
    localparam logic [3:0]  c_TIE_H   = 4'b1111;
    localparam logic [47:0] c_TIE_T   = {12'hFFB, 12'd0, 12'd24, 12'd24};
    localparam logic [3:0]  c_MISS_H  = 4'b1110;
    localparam logic [47:0] c_MISS_T  = {12'h7FF, 12'hFFF, 12'd0, 12'd50};

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        sph_req;
    logic [7:0]  sph_idx;
    logic        isect_valid;
    logic        isect_hit;
    logic [11:0] isect_t;
    logic        out_valid;
    logic        out_ready;
    logic        out_hit;
    logic [7:0]  out_idx;
    logic [11:0] out_t;
    logic [9:0]  out_x;
    logic [9:0]  out_y;
    logic        err;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          first_out;
    int          last_res;
    logic        tr_req [16];
    logic [7:0]  tr_idx [16];

    nearest_hit_scheduler #(.N_SPHERES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .sph_req     (sph_req),
        .sph_idx     (sph_idx),
        .isect_valid (isect_valid),
        .isect_hit   (isect_hit),
        .isect_t     (isect_t),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_hit     (out_hit),
        .out_idx     (out_idx),
        .out_t       (out_t),
        .out_x       (out_x),
        .out_y       (out_y),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record issue activity and the first out_valid cycle.
    task automatic sample(input int cyc);
        if (cyc < 16) begin
            tr_req[cyc] = sph_req;
            tr_idx[cyc] = sph_idx;
        end
        if (out_valid && first_out < 0) first_out = cyc;
    endtask

    // Present a pixel, then feed four results; gap nibble k = idle cycles before result k.
    task automatic run_pixel(input logic [9:0] x, input logic [9:0] y, input logic [3:0] h,
                             input logic [47:0] t, input logic [15:0] gaps);
        int cyc;
        for (int i = 0; i < 16; i++) begin
            tr_req[i] = 1'b0;
            tr_idx[i] = 8'd0;
        end
        first_out = -1;
        last_res  = -1;
        pix_x = x; pix_y = y; pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0; pix_x = 10'd0; pix_y = 10'd0;
        cyc = 1;
        sample(cyc);
        tick(); cyc++;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < int'(gaps[4*k +: 4]); g++) begin
                sample(cyc);
                tick(); cyc++;
            end
            isect_valid = 1'b1;
            isect_hit   = h[k];
            isect_t     = t[12*k +: 12];
            sample(cyc);
            last_res = cyc;
            tick(); cyc++;
            isect_valid = 1'b0; isect_hit = 1'b0; isect_t = 12'd0;
        end
        while (first_out < 0 && cyc < 40) begin
            sample(cyc);
            if (first_out < 0) begin
                tick(); cyc++;
            end
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pix_valid = 1'b1; isect_valid = 1'b1; out_ready = 1'b1;
        isect_hit = 1'b1; isect_t = 12'd5; pix_x = 10'd3; pix_y = 10'd3;
        tick(); tick();
        rst = 1'b0; pix_valid = 1'b0; isect_valid = 1'b0; out_ready = 1'b0;
        isect_hit = 1'b0; isect_t = 12'd0; pix_x = 10'd0; pix_y = 10'd0;
        n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL reset_pix_ready: got %b expected 1", pix_ready); end
        n_checks++; if ({sph_req, sph_idx} !== 9'd0) begin n_fail++; $display("FAIL reset_sph: got req=%b idx=%0d expected 0/0", sph_req, sph_idx); end
        n_checks++; if ({out_valid, out_hit, out_idx} !== 10'd0) begin n_fail++; $display("FAIL reset_out_flags: got v=%b h=%b idx=%0d expected 0", out_valid, out_hit, out_idx); end
        n_checks++; if (out_t !== 12'h7FF) begin n_fail++; $display("FAIL reset_out_t: got %h expected 7ff", out_t); end
        n_checks++; if ({out_x, out_y} !== 20'd0) begin n_fail++; $display("FAIL reset_out_xy: got %0d,%0d expected 0,0", out_x, out_y); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    endtask

    task automatic test_basic();
        run_pixel(10'd5, 10'd7, c_BASIC_H, c_BASIC_T, 16'h0000);
        n_checks++; if (first_out !== 6) begin n_fail++; $display("FAIL basic_latency: got cycle %0d expected 6", first_out); end
        for (int c = 1; c <= 5; c++) begin
            n_checks++;
            if (tr_req[c] !== (c <= 4) || tr_idx[c] !== ((c <= 4) ? 8'(c - 1) : 8'd0)) begin
                n_fail++;
                $display("FAIL basic_issue_c%0d: got req=%b idx=%0d expected req=%b idx=%0d",
                         c, tr_req[c], tr_idx[c], (c <= 4), (c <= 4) ? c - 1 : 0);
            end
        end
        n_checks++; if ({out_valid, out_hit} !== 2'b11) begin n_fail++; $display("FAIL basic_valid_hit: got %b%b expected 11", out_valid, out_hit); end
        n_checks++; if (out_idx !== 8'd1) begin n_fail++; $display("FAIL basic_idx: got %0d expected 1", out_idx); end
        n_checks++; if (out_t !== 12'd24) begin n_fail++; $display("FAIL basic_t: got %0d expected 24", out_t); end
        n_checks++; if ({out_x, out_y} !== {10'd5, 10'd7}) begin n_fail++; $display("FAIL basic_xy: got %0d,%0d expected 5,7", out_x, out_y); end
        n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_in_out: got %b expected 0", pix_ready); end
        handshake();
        n_checks++; if ({out_valid, pix_ready} !== 2'b01) begin n_fail++; $display("FAIL basic_after_hs: got valid=%b ready=%b expected 0/1", out_valid, pix_ready); end
        n_checks++; if ({out_hit, out_idx, out_t, out_x, out_y} !== {1'b0, 8'd0, 12'h7FF, 20'd0}) begin n_fail++; $display("FAIL basic_idle_fields: got %h expected %h", {out_hit, out_idx, out_t, out_x, out_y}, {1'b0, 8'd0, 12'h7FF, 20'd0}); end
    endtask

    task automatic test_tie_and_miss();
        run_pixel(10'd1, 10'd2, c_TIE_H, c_TIE_T, 16'h0000);
        n_checks++; if ({out_valid, out_hit, out_idx, out_t} !== {2'b11, 8'd0, 12'd24}) begin n_fail++; $display("FAIL tie_result: got v=%b h=%b idx=%0d t=%0d expected 1 1 0 24", out_valid, out_hit, out_idx, out_t); end
        handshake();
        run_pixel(10'd3, 10'd4, c_MISS_H, c_MISS_T, 16'h0000);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL miss_valid: got %b expected 1", out_valid); end
        n_checks++; if ({out_hit, out_idx} !== 9'd0) begin n_fail++; $display("FAIL miss_hit_idx: got h=%b idx=%0d expected 0 0", out_hit, out_idx); end
        n_checks++; if (out_t !== 12'h7FF) begin n_fail++; $display("FAIL miss_t: got %h expected 7ff", out_t); end
        n_checks++; if ({out_x, out_y} !== {10'd3, 10'd4}) begin n_fail++; $display("FAIL miss_xy: got %0d,%0d expected 3,4", out_x, out_y); end
        handshake();
    endtask

    task automatic test_backpressure();
        run_pixel(10'd100, 10'd200, c_BASIC_H, c_BASIC_T, 16'h0000);
        n_checks++; if (first_out !== 6) begin n_fail++; $display("FAIL bp_latency: got cycle %0d expected 6", first_out); end
        for (int i = 0; i < 10; i++) begin
            pix_valid = (i == 3);
            pix_x = 10'd999; pix_y = 10'd888;
            n_checks++;
            if ({pix_ready, out_valid, out_hit, out_idx, out_t, out_x, out_y} !==
                {1'b0, 1'b1, 1'b1, 8'd1, 12'd24, 10'd100, 10'd200}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got ready=%b v=%b h=%b idx=%0d t=%0d xy=%0d,%0d expected 0 1 1 1 24 100,200",
                         i, pix_ready, out_valid, out_hit, out_idx, out_t, out_x, out_y);
            end
            tick();
        end
        pix_valid = 1'b0; pix_x = 10'd0; pix_y = 10'd0;
        handshake();
        tick();
        n_checks++; if ({pix_ready, sph_req, out_valid} !== 3'b100) begin n_fail++; $display("FAIL bp_not_captured: got ready=%b req=%b v=%b expected 1 0 0", pix_ready, sph_req, out_valid); end
    endtask

    task automatic test_variable_latency();
        run_pixel(10'd9, 10'd11, c_BASIC_H, c_BASIC_T, 16'h5300);
        n_checks++; if (last_res !== 13) begin n_fail++; $display("FAIL varlat_last_result: got cycle %0d expected 13", last_res); end
        n_checks++; if (first_out !== 14) begin n_fail++; $display("FAIL varlat_latency: got cycle %0d expected 14", first_out); end
        n_checks++; if ({out_hit, out_idx, out_t, out_x, out_y} !== {1'b1, 8'd1, 12'd24, 10'd9, 10'd11}) begin n_fail++; $display("FAIL varlat_result: got h=%b idx=%0d t=%0d xy=%0d,%0d expected 1 1 24 9,11", out_hit, out_idx, out_t, out_x, out_y); end
        handshake();
    endtask

    task automatic test_reset_drain();
        pix_x = 10'd20; pix_y = 10'd30; pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
        tick();
        isect_valid = 1'b1; isect_hit = 1'b1; isect_t = 12'd10;
        tick();
        isect_t = 12'd5;
        tick();
        isect_valid = 1'b0; isect_hit = 1'b0; isect_t = 12'd0;
        tick();
        n_checks++; if ({pix_ready, sph_req, out_valid} !== 3'b000) begin n_fail++; $display("FAIL rd_in_drain: got ready=%b req=%b v=%b expected 0 0 0", pix_ready, sph_req, out_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if ({pix_ready, sph_req, sph_idx, out_valid, out_hit, out_idx, out_t, out_x, out_y, err} !==
                        {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 12'h7FF, 20'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL rd_reset_values: got ready=%b req=%b v=%b h=%b idx=%0d t=%h xy=%0d,%0d err=%b",
                     pix_ready, sph_req, out_valid, out_hit, out_idx, out_t, out_x, out_y, err);
        end
        repeat (2) begin
            isect_valid = 1'b1; isect_hit = 1'b1; isect_t = 12'd3;
            tick();
        end
        isect_valid = 1'b0; isect_hit = 1'b0; isect_t = 12'd0;
        n_checks++; if ({err, out_valid, pix_ready} !== 3'b001) begin n_fail++; $display("FAIL rd_stragglers: got err=%b v=%b ready=%b expected 0 0 1", err, out_valid, pix_ready); end
        run_pixel(10'd2, 10'd3, c_BASIC_H, c_BASIC_T, 16'h0000);
        n_checks++; if (first_out !== 6) begin n_fail++; $display("FAIL rd_next_latency: got cycle %0d expected 6", first_out); end
        n_checks++; if ({out_hit, out_idx, out_t, out_x, out_y} !== {1'b1, 8'd1, 12'd24, 10'd2, 10'd3}) begin n_fail++; $display("FAIL rd_next_result: got h=%b idx=%0d t=%0d xy=%0d,%0d expected 1 1 24 2,3", out_hit, out_idx, out_t, out_x, out_y); end
        handshake();
    endtask

    task automatic test_err();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_initial: got %b expected 0", err); end
        run_pixel(10'd1, 10'd1, c_BASIC_H, c_BASIC_T, 16'h0000);
        isect_valid = 1'b1; isect_hit = 1'b1; isect_t = 12'd1;
        tick();
        isect_valid = 1'b0; isect_hit = 1'b0; isect_t = 12'd0;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", err); end
        n_checks++; if ({out_valid, out_hit, out_idx, out_t} !== {2'b11, 8'd1, 12'd24}) begin n_fail++; $display("FAIL err_result_kept: got v=%b h=%b idx=%0d t=%0d expected 1 1 1 24", out_valid, out_hit, out_idx, out_t); end
        handshake();
        run_pixel(10'd4, 10'd4, c_TIE_H, c_TIE_T, 16'h0000);
        n_checks++; if ({err, out_idx, out_t} !== {1'b1, 8'd0, 12'd24}) begin n_fail++; $display("FAIL err_sticky: got err=%b idx=%0d t=%0d expected 1 0 24", err, out_idx, out_t); end
        handshake();
        tick();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky_idle: got %b expected 1", err); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b expected 0", err); end
    endtask

    initial begin
        rst = 1'b1; pix_valid = 1'b0; pix_x = 10'd0; pix_y = 10'd0;
        isect_valid = 1'b0; isect_hit = 1'b0; isect_t = 12'd0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_tie_and_miss();
        test_backpressure();
        test_variable_latency();
        test_reset_drain();
        test_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nearest_hit_scheduler.md
NEAREST_HIT_SCHEDULER -- requirements
Module: nearest_hit_scheduler

Interface
REQ-001 The block SHALL have parameter N_SPHERES, default 4, giving the number of spheres scanned per pixel (legal range 1..255).
REQ-002 The block SHALL have these ports, in this order:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pix_valid  in  1  pixel request valid.
- pix_ready  out  1  scheduler can accept a pixel.
- pix_x  in  10  pixel column.
- pix_y  in  10  pixel row.
- sph_req  out  1  issue one intersection test this cycle.
- sph_idx  out  8  sphere index being issued.
- isect_valid  in  1  intersection result valid this cycle.
- isect_hit  in  1  ray hit the sphere.
- isect_t  in  12  signed Q8.4 hit distance.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_hit  out  1  some sphere was hit.
- out_idx  out  8  index of the nearest hit sphere.
- out_t  out  12  signed nearest hit distance.
- out_x  out  10  captured pixel column.
- out_y  out  10  captured pixel row.
- err  out  1  sticky protocol-error flag.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, ISSUE, DRAIN and OUT.
REQ-004 pix_ready SHALL be 1 only in IDLE.
REQ-005 In IDLE, pix_valid=1 SHALL cause the following, then a move to ISSUE on the same edge:
- capture pix_x and pix_y;
- clear issue_cnt and rcv_cnt;
- set best_hit=0, best_idx=0, best_t=12'sh7FF.
REQ-006 In ISSUE, sph_req SHALL be 1 and sph_idx SHALL equal issue_cnt; issue_cnt SHALL increment every cycle.
REQ-007 ISSUE SHALL move to DRAIN after the cycle in which issue_cnt equals N_SPHERES-1, so ISSUE lasts exactly N_SPHERES cycles.
REQ-008 sph_req SHALL be 0 in every state other than ISSUE.
REQ-009 Results SHALL be taken to arrive in issue order, with latency of at least 1 cycle, in ISSUE or DRAIN.
REQ-010 Each isect_valid cycle in ISSUE or DRAIN SHALL increment rcv_cnt; the result belongs to sphere index rcv_cnt before the increment.
REQ-011 A result SHALL replace the current best only when all of the following hold:
- isect_hit=1;
- isect_t > 0;
- isect_t < best_t, using a signed strict compare.
REQ-012 On replacement, best_hit SHALL become 1, best_idx SHALL become the result's index and best_t SHALL become isect_t.
REQ-013 Equal distances SHALL keep the lower index.
REQ-014 isect_t <= 0 SHALL count as a miss.
REQ-015 isect_t = 2047 SHALL never be selected.
REQ-016 DRAIN SHALL move to OUT on the edge where isect_valid=1 and rcv_cnt=N_SPHERES-1.
REQ-017 Latency: with result latency LAT >= 1 and acceptance at edge 0, out_valid SHALL first be 1 in cycle N_SPHERES+LAT+1.
REQ-018 In OUT, out_valid SHALL be 1, and out_hit, out_idx, out_t, out_x and out_y SHALL hold the best and captured values, stable until the handshake.
REQ-019 With no qualifying hit, OUT SHALL present out_hit=0, out_idx=0 and out_t=12'sh7FF.
REQ-020 An OUT cycle with out_ready=1 SHALL complete the handshake and return the FSM to IDLE.
REQ-021 A new pixel SHALL be accepted no earlier than the cycle after the output handshake, leaving a 1-cycle bubble.
REQ-022 pix_valid outside IDLE SHALL be ignored and SHALL NOT be captured later.
REQ-023 isect_valid in IDLE SHALL be ignored, so in-flight results after a reset are discarded silently.
REQ-024 isect_valid in OUT SHALL set err=1 and SHALL NOT change any result.
REQ-025 err SHALL clear only on reset.
REQ-026 The output fields SHALL be 0 whenever out_valid=0, except out_t, which SHALL read 12'sh7FF.
REQ-027 Counters SHALL be 9 bits wide so that N_SPHERES=255 cannot wrap.
REQ-028 With N_SPHERES=1, ISSUE SHALL last exactly one cycle.

Reset
REQ-029 When rst=1 at a rising edge, the next state SHALL be IDLE regardless of the current state, including mid-ISSUE, mid-DRAIN and OUT.
REQ-030 After reset the outputs SHALL be:
- pix_ready=1;
- sph_req=0, sph_idx=0;
- out_valid=0, out_hit=0, out_idx=0, out_t=12'sh7FF, out_x=0, out_y=0;
- err=0.
REQ-031 rst SHALL take priority over pix_valid, isect_valid and out_ready in the same cycle.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Basic nearest hit: N=4, LAT=1, pixel (5,7); results hit/t = (1,40),(1,24),(0,x),(1,30) -> out_valid in cycle 6, out_hit=1, out_idx=1, out_t=24, out_x=5, out_y=7.
- Tie and invalid t: results (1,24),(1,24),(1,0),(1,-5) -> out_idx=0, out_t=24; all misses -> out_hit=0, out_idx=0, out_t=2047.
- Backpressure: out_ready held 0 for 10 cycles -> out_valid and all fields stable; pix_ready=0 throughout; pix_valid pulsed in that window is not captured.
- Variable latency: results delivered with gaps of 0, 3 and 5 idle cycles -> same result as the gapless case; out_valid the cycle after the 4th result.
- Reset mid-DRAIN after 2 results: outputs return to reset values; 2 straggling isect_valid pulses in IDLE leave err=0; the next pixel computes correctly.
- Extra result while in OUT -> err=1 and sticky through subsequent pixels until rst.
